// File: rtl/majority_voter_pkg.sv
// Shared constants and helpers for the N-channel majority voter.
// Holds the parameter bounds and the fault-counter width calculation.
package majority_voter_pkg;

    localparam int MAX_N         = 7;
    localparam int ERR_LIMIT_MAX = 15;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/majority_slice.sv
// One-bit masked majority vote across N channels.
// A tie among an even number of active channels resolves to the lowest-indexed active channel.
module majority_slice
    import majority_voter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] bits,
    input  logic [N-1:0] active,
    output logic         vote
);

    localparam int SW = $clog2(MAX_N + 1);

    logic [SW-1:0] ones;
    logic [SW-1:0] act;
    logic          low_bit;

    always_comb begin
        ones    = '0;
        act     = '0;
        low_bit = 1'b0;
        // Walking downward leaves low_bit holding the lowest active channel's bit.
        for (int k = N - 1; k >= 0; k--) begin
            if (active[k]) begin
                act     = act + SW'(1);
                ones    = ones + SW'(bits[k]);
                low_bit = bits[k];
            end
        end
        if ({ones, 1'b0} > {1'b0, act}) begin
            vote = 1'b1;
        end else if ({ones, 1'b0} == {1'b0, act}) begin
            vote = low_bit;
        end else begin
            vote = 1'b0;
        end
    end

endmodule

// File: rtl/majority_voter_seq.sv
// Registered N-channel bitwise majority voter with per-channel persistent-fault
// counters, sticky channel masking and a guard that keeps at least one channel voting.
module majority_voter_seq
    import majority_voter_pkg::*;
#(
    parameter int N         = 3,
    parameter int WIDTH     = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               clear_faults,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [N-1:0]       mismatch,
    output logic [N-1:0]       fault_mask,
    output logic               degraded
);

    localparam int             CW    = cnt_width(ERR_LIMIT);
    localparam logic [CW-1:0]  LIMIT = CW'(ERR_LIMIT);

    if (N > MAX_N || N < 3 || (N % 2) == 0 || ERR_LIMIT < 1 || ERR_LIMIT > ERR_LIMIT_MAX) begin : g_param_check
        $error("majority_voter_seq: parameter out of range");
    end

    logic [N-1:0]     mask_q, mask_d, active, mism_p0, newly, keep;
    logic [CW-1:0]    cnt_q [N];
    logic [CW-1:0]    cnt_d [N];
    logic [N-1:0]     col [WIDTH];
    logic [WIDTH-1:0] voted_p0;
    logic [WIDTH-1:0] data_p1;
    logic [N-1:0]     mism_p1;
    logic             vld_p1;

    assign active = ~mask_q;

    always_comb begin
        for (int b = 0; b < WIDTH; b++) begin
            for (int k = 0; k < N; k++) begin
                col[b][k] = in_data[k*WIDTH + b];
            end
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_slice
        majority_slice #(.N(N)) u_slice (
            .bits   (col[b]),
            .active (active),
            .vote   (voted_p0[b])
        );
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            mism_p0[k] = active[k] && (in_data[k*WIDTH +: WIDTH] != voted_p0);
        end
    end

    always_comb begin
        mask_d = mask_q;
        newly  = '0;
        keep   = '0;
        for (int k = 0; k < N; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (in_valid) begin
            for (int k = 0; k < N; k++) begin
                if (active[k]) begin
                    if (mism_p0[k]) begin
                        cnt_d[k] = (cnt_q[k] == LIMIT) ? LIMIT : cnt_q[k] + CW'(1);
                    end else begin
                        cnt_d[k] = '0;
                    end
                    newly[k] = (cnt_d[k] == LIMIT);
                end
            end
            // If every channel would end up masked, spare the lowest newly-failing one.
            if (&(mask_q | newly)) begin
                keep = newly & (~newly + N'(1));
            end
            mask_d = mask_q | (newly & ~keep);
            for (int k = 0; k < N; k++) begin
                if (keep[k]) begin
                    cnt_d[k] = '0;
                end
            end
        end
        if (clear_faults) begin
            mask_d = '0;
            for (int k = 0; k < N; k++) begin
                cnt_d[k] = '0;
            end
        end
    end

    // ---- stage p0 -> p1: output register, counters and mask ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            mism_p1 <= '0;
            mask_q  <= '0;
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            vld_p1  <= in_valid;
            mism_p1 <= in_valid ? mism_p0 : '0;
            if (in_valid) begin
                data_p1 <= voted_p0;
            end
            mask_q <= mask_d;
            for (int k = 0; k < N; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign out_valid  = vld_p1;
    assign out_data   = data_p1;
    assign mismatch   = mism_p1;
    assign fault_mask = mask_q;
    assign degraded   = |mask_q;

endmodule

// File: tb/tb_majority_voter_seq.sv
// Table-driven bench for majority_voter_seq (N=3, WIDTH=8, ERR_LIMIT=4) with an
// expected-result queue, plus hand-written async-reset corner cases.
module tb_majority_voter_seq;

    localparam int N     = 3;
    localparam int WIDTH = 8;

    typedef struct {
        logic       v;
        logic       clr;
        logic [7:0] c0, c1, c2;
        logic [7:0] ed;
        logic [2:0] em;
        logic [2:0] emask;
    } row_t;

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic [2:0] mism;
        logic [2:0] mask;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic               clear_faults;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [N-1:0]       mismatch;
    logic [N-1:0]       fault_mask;
    logic               degraded;

    int checks   = 0;
    int failures = 0;

    row_t tbl[$];
    exp_t sbq[$];

    majority_voter_seq #(.N(3), .WIDTH(8), .ERR_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .clear_faults (clear_faults),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .mismatch     (mismatch),
        .fault_mask   (fault_mask),
        .degraded     (degraded)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic v, input logic clr,
                                input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                                input logic [7:0] ed, input logic [2:0] em, input logic [2:0] emask);
        row_t r;
        r.v = v; r.clr = clr; r.c0 = c0; r.c1 = c1; r.c2 = c2;
        r.ed = ed; r.em = em; r.emask = emask;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sbq.pop_front();
            check({tag, ".out_valid"},  32'(out_valid),  32'(e.vld));
            check({tag, ".out_data"},   32'(out_data),   32'(e.data));
            check({tag, ".mismatch"},   32'(mismatch),   32'(e.mism));
            check({tag, ".fault_mask"}, 32'(fault_mask), 32'(e.mask));
            check({tag, ".degraded"},   32'(degraded),   32'(|e.mask));
        end
    endtask

    task automatic run_row(input row_t r, input int idx);
        exp_t e;
        @(negedge clk);
        in_valid     = r.v;
        clear_faults = r.clr;
        in_data      = {r.c2, r.c1, r.c0};
        e.vld  = r.v;
        e.data = r.ed;
        e.mism = r.em;
        e.mask = r.emask;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        compare_out($sformatf("row%0d", idx));
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        clear_faults = 1'b0;

        // Basic votes and a single-sample disagreement
        tbl.push_back(mk(1, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 3'b000, 3'b000));
        tbl.push_back(mk(1, 0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 3'b100, 3'b000));
        tbl.push_back(mk(1, 0, 8'h11, 8'h11, 8'h11, 8'h11, 3'b000, 3'b000));
        // ch1 wrong four times in a row: masked after the fourth
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 0, 8'h22, 8'h33, 8'h22, 8'h22, 3'b010, 3'b000));
        tbl.push_back(mk(1, 0, 8'h22, 8'h33, 8'h22, 8'h22, 3'b010, 3'b010));
        // Tie between ch0 and ch2 goes to ch0
        tbl.push_back(mk(1, 0, 8'h0F, 8'h0F, 8'hF0, 8'h0F, 3'b100, 3'b010));
        // Clear together with a mismatching sample: voted with ch1 still masked
        tbl.push_back(mk(1, 1, 8'h0F, 8'hAA, 8'hF0, 8'h0F, 3'b100, 3'b000));
        // ch2 wrong three times (with a gap) must not mask if counters were cleared
        tbl.push_back(mk(1, 0, 8'h01, 8'h01, 8'h02, 8'h01, 3'b100, 3'b000));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 3'b000, 3'b000));
        tbl.push_back(mk(1, 0, 8'h01, 8'h01, 8'h02, 8'h01, 3'b100, 3'b000));
        tbl.push_back(mk(1, 0, 8'h01, 8'h01, 8'h02, 8'h01, 3'b100, 3'b000));
        tbl.push_back(mk(1, 0, 8'h01, 8'h01, 8'h01, 8'h01, 3'b000, 3'b000));
        // ch1 wrong 3, right 1, wrong 3, with idle gaps: never masked
        tbl.push_back(mk(1, 0, 8'h40, 8'h41, 8'h40, 8'h40, 3'b010, 3'b000));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h40, 3'b000, 3'b000));
        tbl.push_back(mk(1, 0, 8'h40, 8'h41, 8'h40, 8'h40, 3'b010, 3'b000));
        tbl.push_back(mk(1, 0, 8'h40, 8'h41, 8'h40, 8'h40, 3'b010, 3'b000));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h40, 3'b000, 3'b000));
        tbl.push_back(mk(1, 0, 8'h40, 8'h40, 8'h40, 8'h40, 3'b000, 3'b000));
        tbl.push_back(mk(1, 0, 8'h40, 8'h41, 8'h40, 8'h40, 3'b010, 3'b000));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 8'h40, 3'b000, 3'b000));
        tbl.push_back(mk(1, 0, 8'h40, 8'h41, 8'h40, 8'h40, 3'b010, 3'b000));
        tbl.push_back(mk(1, 0, 8'h40, 8'h41, 8'h40, 8'h40, 3'b010, 3'b000));
        tbl.push_back(mk(1, 0, 8'h50, 8'h50, 8'h50, 8'h50, 3'b000, 3'b000));
        // Every channel wrong on a different bit: guard keeps ch0 voting
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 0, 8'hFE, 8'hFD, 8'hFB, 8'hFF, 3'b111, 3'b000));
        tbl.push_back(mk(1, 0, 8'hFE, 8'hFD, 8'hFB, 8'hFF, 3'b111, 3'b110));
        tbl.push_back(mk(1, 0, 8'h12, 8'h34, 8'h56, 8'h12, 3'b000, 3'b110));
        tbl.push_back(mk(1, 0, 8'hC3, 8'h00, 8'hFF, 8'hC3, 3'b000, 3'b110));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h00, 8'hC3, 3'b000, 3'b110));

        // Reset state
        #12;
        check("reset.out_valid",  32'(out_valid),  32'd0);
        check("reset.out_data",   32'(out_data),   32'd0);
        check("reset.mismatch",   32'(mismatch),   32'd0);
        check("reset.fault_mask", 32'(fault_mask), 32'd0);
        check("reset.degraded",   32'(degraded),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_row(tbl[i], i);

        // Asynchronous reset mid-stream while degraded and holding data
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {8'h77, 8'h77, 8'h77};
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.out_valid",  32'(out_valid),  32'd0);
        check("async_rst.out_data",   32'(out_data),   32'd0);
        check("async_rst.mismatch",   32'(mismatch),   32'd0);
        check("async_rst.fault_mask", 32'(fault_mask), 32'd0);
        check("async_rst.degraded",   32'(degraded),   32'd0);
        @(posedge clk);
        #1;
        check("rst_hold.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // First sample after reset votes with all channels active
        run_row(mk(1, 0, 8'h0F, 8'h0F, 8'hF0, 8'h0F, 3'b100, 3'b000), 100);

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle.out_valid", 32'(out_valid), 32'd0);
        check("idle.out_data",  32'(out_data),  32'h0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
